// File: rtl/rx_seq_strip_pkg.sv
// Shared defaults and FSM state type for the RX sequence-strip stage.
package rx_seq_strip_pkg;

  localparam int SEQ_W_DEF     = 32;
  localparam int CNT_W_DEF     = 32;
  localparam int MAX_WORDS_DEF = 256;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_seq_strip_seq_tracker.sv
// Sequence continuity tracker: remembers the last sequence number, flags gaps and
// keeps a saturating error count. The first number after reset is always accepted.
module rx_seq_strip_seq_tracker
  import rx_seq_strip_pkg::*;
#(
  parameter int DATA_W = SEQ_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              user_clk,
  input  logic              sys_reset,
  input  logic              check,
  input  logic [DATA_W-1:0] seq_in,
  output logic [DATA_W-1:0] seq_last,
  output logic              seq_err,
  output logic [CNT_W-1:0]  seq_err_cnt
);

  logic first_seq;
  logic mismatch;

  assign mismatch = !first_seq && (seq_in != (seq_last + DATA_W'(1)));

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      seq_last    <= '0;
      first_seq   <= 1'b1;
      seq_err     <= 1'b0;
      seq_err_cnt <= '0;
    end else begin
      seq_err <= check && mismatch;
      if (check) begin
        // Always resynchronise so a single jump costs exactly one error.
        seq_last  <= seq_in;
        first_seq <= 1'b0;
        if (mismatch && !(&seq_err_cnt))
          seq_err_cnt <= seq_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rx_seq_strip.sv
// Removes the trailing sequence word of each RX frame, moving tlast onto the last
// payload word, or passes frames through registered when stripping is disabled.
module rx_seq_strip
  import rx_seq_strip_pkg::*;
#(
  parameter int DATA_W    = SEQ_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              user_clk,
  input  logic              sys_reset,
  // Handshake: no back-pressure on either side; a word transfers on every cycle
  // its tvalid is high, and m_axis_tvalid is high exactly one cycle per word.
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              strip_en,
  output logic [DATA_W-1:0] seq_last,
  output logic              seq_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [CNT_W-1:0]  runt_cnt,
  output logic [CNT_W-1:0]  oversize_cnt,
  output rx_state_e         state_dbg
);

  localparam int WC_W = $clog2(MAX_WORDS + 2);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] WC_TRIG = WC_W'(MAX_WORDS);

  rx_state_e         state, state_d;
  logic              mode_q;
  logic [DATA_W-1:0] hold;
  logic [WC_W-1:0]   wcnt;
  logic              over_flag;
  logic              cur_strip;
  logic              end_word;
  logic              seq_check;

  // The mode is taken live from strip_en on a frame's first word, then held.
  assign cur_strip = (state == ST_IDLE) ? strip_en : mode_q;
  assign end_word  = s_axis_tvalid && s_axis_tlast;
  assign seq_check = end_word && cur_strip;
  assign state_dbg = state;

  always_comb begin
    state_d = state;
    if (s_axis_tvalid)
      state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
  end

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      state         <= ST_IDLE;
      mode_q        <= 1'b1;
      hold          <= '0;
      wcnt          <= '0;
      over_flag     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_cnt     <= '0;
      runt_cnt      <= '0;
      oversize_cnt  <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && s_axis_tvalid)
        mode_q <= strip_en;

      if (!cur_strip) begin
        m_axis_tvalid <= s_axis_tvalid;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tlast  <= end_word;
      end else begin
        m_axis_tvalid <= s_axis_tvalid && (state == ST_BODY);
        m_axis_tdata  <= hold;
        m_axis_tlast  <= end_word && (state == ST_BODY);
      end

      if (s_axis_tvalid && cur_strip) begin
        if (s_axis_tlast) begin
          wcnt      <= '0;
          over_flag <= 1'b0;
        end else begin
          hold <= s_axis_tdata;
          if (state == ST_IDLE)
            wcnt <= WC_W'(1);
          else if (wcnt != WC_MAX)
            wcnt <= wcnt + WC_W'(1);
          // wcnt is about to reach MAX_WORDS+1 payload words.
          if (state == ST_BODY && wcnt == WC_TRIG && !over_flag) begin
            over_flag <= 1'b1;
            if (!(&oversize_cnt))
              oversize_cnt <= oversize_cnt + CNT_W'(1);
          end
        end
      end

      if (end_word && !(&frame_cnt))
        frame_cnt <= frame_cnt + CNT_W'(1);
      if (seq_check && state == ST_IDLE && !(&runt_cnt))
        runt_cnt <= runt_cnt + CNT_W'(1);
    end
  end

  rx_seq_strip_seq_tracker #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_seq_tracker (
    .user_clk   (user_clk),
    .sys_reset  (sys_reset),
    .check      (seq_check),
    .seq_in     (s_axis_tdata),
    .seq_last   (seq_last),
    .seq_err    (seq_err),
    .seq_err_cnt(seq_err_cnt)
  );

endmodule

// File: tb/tb_rx_seq_strip.sv
// Bench for rx_seq_strip: frame-level reference model, output scoreboard and
// register/status checks at frame boundaries.
module tb_rx_seq_strip;
  import rx_seq_strip_pkg::*;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 32;
  localparam int MAX_WORDS = 256;

  logic              user_clk = 1'b0;
  logic              sys_reset = 1'b1;
  logic              s_axis_tvalid = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              m_axis_tvalid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              strip_en = 1'b1;
  logic [DATA_W-1:0] seq_last;
  logic              seq_err;
  logic [CNT_W-1:0]  frame_cnt, seq_err_cnt, runt_cnt, oversize_cnt;
  rx_state_e         state_dbg;

  rx_seq_strip #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_WORDS(MAX_WORDS)) dut (
    .user_clk(user_clk), .sys_reset(sys_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .strip_en(strip_en), .seq_last(seq_last), .seq_err(seq_err),
    .frame_cnt(frame_cnt), .seq_err_cnt(seq_err_cnt), .runt_cnt(runt_cnt),
    .oversize_cnt(oversize_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 user_clk = ~user_clk;

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];   // {tlast, tdata}
  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  // Reference model of the status registers, frame-level.
  logic [DATA_W-1:0] m_seq_last;
  bit                m_first;
  int                m_frames, m_runts, m_over, m_errs, m_err_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic model_reset();
    m_seq_last = '0;
    m_first    = 1'b1;
    m_frames   = 0;
    m_runts    = 0;
    m_over     = 0;
    m_errs     = 0;
  endtask

  task automatic do_reset();
    sys_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    tick();
    tick();
    sys_reset = 1'b0;
    model_reset();
  endtask

  task automatic check_status(input string tag);
    check({tag, ".frame_cnt"},    64'(frame_cnt),    64'(m_frames));
    check({tag, ".runt_cnt"},     64'(runt_cnt),     64'(m_runts));
    check({tag, ".oversize_cnt"}, 64'(oversize_cnt), 64'(m_over));
    check({tag, ".seq_err_cnt"},  64'(seq_err_cnt),  64'(m_errs));
    check({tag, ".seq_last"},     64'(seq_last),     64'(m_seq_last));
  endtask

  // ---------------- driver ----------------
  // n_pay payload words then the sequence word; in pass-through mode every word is payload.
  task automatic send_frame(input int n_pay, input logic [DATA_W-1:0] seq, input bit strip,
                            input bit toggle, input int gap_max);
    logic [DATA_W-1:0] words[$];
    bit exp_err;
    exp_err = 1'b0;
    for (int i = 0; i < n_pay; i++) words.push_back(DATA_W'($urandom));
    words.push_back(seq);

    if (strip) begin
      for (int i = 0; i < n_pay; i++) exp_q.push_back({i == n_pay - 1, words[i]});
      if (n_pay == 0) m_runts++;
      if (n_pay > MAX_WORDS) m_over++;
      if (!m_first && seq != m_seq_last + DATA_W'(1)) exp_err = 1'b1;
      if (exp_err) begin m_errs++; m_err_total++; end
      m_first    = 1'b0;
      m_seq_last = seq;
    end else begin
      for (int i = 0; i <= n_pay; i++) exp_q.push_back({i == n_pay, words[i]});
    end
    m_frames++;

    for (int i = 0; i <= n_pay; i++) begin
      if (i > 0) begin
        int gaps;
        gaps = $urandom_range(0, gap_max);
        s_axis_tvalid = 1'b0;
        repeat (gaps) tick();
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = words[i];
      s_axis_tlast  = (i == n_pay);
      if (i == 0) strip_en = strip;
      tick();
      if (i == 0 && toggle) strip_en = !strip;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("seq_err_pulse", 64'(seq_err), 64'(exp_err));
    tick();
    tick();
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge user_clk);
      if (seq_err) err_pulses++;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got data 0x%0h last %0b expected no output",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          checks++;
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            failures++;
            $display("FAIL out_word: got last %0b data 0x%0h expected last %0b data 0x%0h",
                     m_axis_tlast, m_axis_tdata, e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_err_total = 0;
    model_reset();
    do_reset();
    check("rst.m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst.seq_err", 64'(seq_err), 64'd0);
    check("rst.state", 64'(state_dbg), 64'(ST_IDLE));
    check_status("rst");

    // Basic stripping.
    send_frame(3, 32'd5, 1'b1, 1'b0, 2);
    send_frame(1, 32'd6, 1'b1, 1'b0, 2);
    check_status("t1");

    // Sequence gap: one error only.
    do_reset();
    send_frame(2, 32'd10, 1'b1, 1'b0, 1);
    send_frame(2, 32'd11, 1'b1, 1'b0, 1);
    send_frame(2, 32'd13, 1'b1, 1'b0, 1);
    send_frame(2, 32'd14, 1'b1, 1'b0, 1);
    check_status("t2");

    // Wraparound, and first frame after reset.
    do_reset();
    send_frame(1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    send_frame(1, 32'h0000_0000, 1'b1, 1'b0, 0);
    check_status("t3a");
    do_reset();
    send_frame(2, 32'h1234, 1'b1, 1'b0, 0);
    check_status("t3b");

    // Runt frame.
    do_reset();
    send_frame(0, 32'd7, 1'b1, 1'b0, 0);
    check_status("t4");

    // Pass-through, mid-frame toggles, oversize boundaries.
    do_reset();
    send_frame(1, 32'hABCD, 1'b0, 1'b0, 1);
    send_frame(3, 32'h55, 1'b0, 1'b1, 2);
    send_frame(3, 32'd20, 1'b1, 1'b1, 2);
    send_frame(0, 32'h77, 1'b0, 1'b0, 0);
    send_frame(MAX_WORDS, 32'd21, 1'b1, 1'b0, 0);
    check_status("t5a");
    send_frame(MAX_WORDS + 3, 32'd22, 1'b1, 1'b0, 0);
    send_frame(MAX_WORDS + 1, 32'd23, 1'b1, 1'b0, 0);
    check_status("t5b");

    // Reset with a word held mid-frame.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_BEEF;
    s_axis_tlast  = 1'b0;
    strip_en      = 1'b1;
    tick();
    do_reset();
    tick();
    check("t6.m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_status("t6a");
    send_frame(1, 32'd99, 1'b1, 1'b0, 0);
    check_status("t6b");

    // Randomised traffic.
    for (int f = 0; f < 40; f++) begin
      logic [DATA_W-1:0] s;
      s = ($urandom_range(0, 4) == 0) ? DATA_W'($urandom) : m_seq_last + DATA_W'(1);
      send_frame($urandom_range(0, 6), s, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), 3);
    end
    check_status("rand");

    repeat (4) tick();
    check("err_pulse_total", 64'(err_pulses), 64'(m_err_total));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("end.state", 64'(state_dbg), 64'(ST_IDLE));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
